match_sched: RTL and testbench
==============================

MATCH_SCHED -- requirements
Module: match_sched

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter RUN_LEN, default 4, SHALL set the consecutive A==B samples needed for a hit (1..15).
REQ-003 Parameter TIMEOUT, default 32, SHALL set the maximum RUN cycles per grant (used only under REQ-025).
REQ-004 Port clk, input, 1, SHALL be the single clock, rising-edge active.
REQ-005 Port reset, input, 1, SHALL be an asynchronous, active-low reset.
REQ-006 Port req, input, N_REQ, SHALL be per-requester level request, held until done or abandoned.
REQ-007 Port a, input, N_REQ, SHALL be per-requester A stream bit.
REQ-008 Port b, input, N_REQ, SHALL be per-requester B stream bit.
REQ-009 Port gnt, output, N_REQ, SHALL be registered one-hot grant, all-zero when no grant.
REQ-010 Port done, output, 1, SHALL be a registered one-cycle completion pulse.
REQ-011 Port hit, output, 1, SHALL be the result, valid only while done=1.
REQ-012 Port id, output, clog2(N_REQ), SHALL be the granted/completed requester index, valid while gnt!=0 or done=1.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and REPORT.
REQ-014 IDLE: on an edge with any req bit set, SHALL pick the first set bit at or after rr_ptr (wrapping), set gnt/id to it, clear the run count and enter RUN.
REQ-015 RUN: each edge SHALL sample a[id]==b[id]; match increments the run count; mismatch clears it to 0 (no early exit).
REQ-016 RUN: when the count reaches RUN_LEN, the same edge SHALL clear gnt, set done=1 and hit=1, and enter REPORT.
REQ-017 RUN: if req[id] is low when sampled, that edge SHALL clear gnt, keep done=0, set rr_ptr=id+1 mod N_REQ and return to IDLE (abandon); a simultaneous match is ignored.
REQ-018 REPORT: SHALL last exactly one cycle; next edge clears done/hit, sets rr_ptr=id+1 mod N_REQ, enters IDLE.
REQ-019 Latency: req high at edge k SHALL give gnt at k+1; with all matches, done is high from edge k+1+RUN_LEN for one cycle.
REQ-020 Requests from non-granted requesters SHALL be ignored until IDLE; no pre-emption.
REQ-021 The run count SHALL be 4 bits and never exceed RUN_LEN.

Reset
REQ-022 While reset=0, state SHALL be IDLE, gnt=0, done=0, hit=0, id=0, run count=0, rr_ptr=0, asynchronously.
REQ-023 Reset asserted in RUN or REPORT SHALL discard the transaction with no done pulse.
REQ-024 After release, requester 0 SHALL have highest priority.

Configuration
REQ-025 With MATCH_SCHED_TIMEOUT_EN defined, a cycle counter SHALL clear on RUN entry; after TIMEOUT RUN cycles without a hit, SHALL enter REPORT with done=1, hit=0. A hit on the TIMEOUT-th cycle wins.
REQ-026 Without MATCH_SCHED_TIMEOUT_EN, RUN SHALL end only by hit, abandon or reset; no timeout counter SHALL be built.

Structure
REQ-027 Package match_sched_pkg SHALL hold the state enum and default RUN_LEN/TIMEOUT constants.
REQ-028 Sub-module run_detect SHALL hold the consecutive-match counter (inputs clk, reset, clr, en, eq; output reached), instantiated once.

Verification
REQ-029 req=0001, a[0]==b[0] every cycle -> gnt=0001 one cycle after req; done=1, hit=1, id=0 exactly 4 cycles later.
REQ-030 req=0001, pattern eq,eq,neq,eq,eq,eq,eq -> no done until the 7th RUN sample; then done=1, hit=1.
REQ-031 req=1111 held, always matching -> grants in order 0,1,2,3,0, each one done pulse apart.
REQ-032 req[2] granted, dropped after 2 RUN cycles -> gnt=0, no done, next grant goes to index 3 if requesting.
REQ-033 Timeout build, TIMEOUT=8, a!=b always -> done=1, hit=0 after 8 RUN cycles; non-timeout build -> no done after 100 cycles.
REQ-034 reset=0 during RUN at count 3 -> all outputs 0 immediately; after release, req=1000 is granted with no stale done.

Source files
------------

// File: rtl/match_sched_pkg.sv
// match_sched_pkg -- shared types and defaults for the match scheduler.
//   state_t        : scheduler FSM state encoding (IDLE / RUN / REPORT)
//   DEF_*          : default parameter values used by match_sched
//   CNT_W          : width of the consecutive-match counter
// Optional feature macro: MATCH_SCHED_TIMEOUT_EN (used by match_sched).
package match_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_RUN_LEN = 4;
  localparam int DEF_TIMEOUT = 32;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/match_sched_run_detect.sv
// run_detect -- consecutive-match counter for the granted requester.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   clr     : synchronous clear of the count (priority over en)
//   en      : count this cycle's sample
//   eq      : this cycle's sample matched (A == B)
//   reached : combinational; this edge's sample completes RUN_LEN matches
module run_detect
  import match_sched_pkg::*;
#(
  parameter int RUN_LEN = DEF_RUN_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic eq,
  output logic reached
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RUN_LEN);

  logic [CNT_W-1:0] count;

  // The scheduler acts on the same edge that brings the count to RUN_LEN,
  // so the hit is flagged one sample ahead of the stored count.
  assign reached = en & eq & (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (!eq) begin
        count <= '0;
      end else if (count != FULL) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/match_sched.sv
// match_sched -- round-robin scheduler that grants one requester at a time
// and watches its A/B streams for RUN_LEN consecutive equal samples.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   req       : per-requester level request (held until done or abandoned)
//   a, b      : per-requester stream bits compared while granted
//   gnt       : registered one-hot grant, zero when idle
//   done      : registered one-cycle completion pulse
//   hit       : result, meaningful only while done=1
//   id        : granted / completed requester index
//   dbg_state : current FSM state (state_t encoding) for observation
// Handshake: a requester raises req and holds it; the grant runs until a hit
// (done=1,hit=1), a drop of req (abandon, no done) or, in the timeout build,
// TIMEOUT run cycles (done=1,hit=0). No pre-emption.
// Optional feature macro: MATCH_SCHED_TIMEOUT_EN enables the run timeout.
module match_sched
  import match_sched_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int RUN_LEN = DEF_RUN_LEN,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         a,
  input  logic [N_REQ-1:0]         b,
  output logic [N_REQ-1:0]         gnt,
  output logic                     done,
  output logic                     hit,
  output logic [$clog2(N_REQ)-1:0] id,
  output logic [1:0]               dbg_state
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || RUN_LEN < 1 || RUN_LEN > 15 || TIMEOUT < 1) begin : g_param_err
    $error("match_sched: parameter out of range");
  end

  state_t           state, state_d;
  logic [N_REQ-1:0] gnt_d;
  logic             done_d, hit_d;
  logic [IDX_W-1:0] id_d, rr_ptr, rr_d;
  logic [IDX_W-1:0] pick_idx, next_idx;
  logic             pick_valid;
  logic             eq, en, clr, reached, tmo_hit;

  assign dbg_state = state;

  // First requesting index at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    pick_valid = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(rr_ptr) + i) % N_REQ;
      if (!pick_valid && req[j]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  assign next_idx = (id == IDX_W'(N_REQ - 1)) ? '0 : id + 1'b1;

  assign eq  = (a[id] == b[id]);
  // An abandoning edge does not count its sample.
  assign en  = (state == ST_RUN) && req[id];
  assign clr = (state != ST_RUN);

  run_detect #(.RUN_LEN(RUN_LEN)) u_run_detect (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .en      (en),
    .eq      (eq),
    .reached (reached)
  );

`ifdef MATCH_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state != ST_RUN) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // True on the TIMEOUT-th run cycle; a hit on that cycle takes precedence.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    done_d  = 1'b0;
    hit_d   = 1'b0;
    id_d    = id;
    rr_d    = rr_ptr;
    case (state)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          id_d    = pick_idx;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!req[id]) begin
          gnt_d   = '0;
          rr_d    = next_idx;
          state_d = ST_IDLE;
        end else if (reached) begin
          gnt_d   = '0;
          done_d  = 1'b1;
          hit_d   = 1'b1;
          state_d = ST_REPORT;
        end else if (tmo_hit) begin
          gnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        gnt_d   = '0;
        rr_d    = next_idx;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      gnt    <= '0;
      done   <= 1'b0;
      hit    <= 1'b0;
      id     <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_d;
      gnt    <= gnt_d;
      done   <= done_d;
      hit    <= hit_d;
      id     <= id_d;
      rr_ptr <= rr_d;
    end
  end

endmodule

// File: tb/tb_match_sched.sv
// tb_match_sched -- self-checking bench for match_sched (default parameters,
// TIMEOUT=8). A transaction-level reference model predicts grant, done, hit
// and id from the inputs; directed scenarios add fixed-value checks.
// Optional feature macro: MATCH_SCHED_TIMEOUT_EN (model follows the build).
module tb_match_sched;

  localparam int N   = 4;
  localparam int RL  = 4;
  localparam int TMO = 8;
`ifdef MATCH_SCHED_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         req = '0, a = '0, b = '0;
  logic [N-1:0]         gnt;
  logic                 done, hit;
  logic [$clog2(N)-1:0] id;
  logic [1:0]           dbg_state;

  match_sched #(.N_REQ(N), .RUN_LEN(RL), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .done      (done),
    .hit       (hit),
    .id        (id),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one transaction at a time, judged on its sample history
  int m_owner;   // granted requester, -1 when none
  bit m_report;  // a result is being shown this cycle
  bit m_done, m_hit;
  int m_id, m_ptr, m_runs;
  bit hist[$];

  function automatic int trailing_matches();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (!hist[i]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_report = 0; m_done = 0; m_hit = 0;
    m_id = 0; m_ptr = 0; m_runs = 0;
    hist.delete();
  endtask

  task automatic model_edge();
    if (m_report) begin
      m_report = 0; m_done = 0; m_hit = 0;
      m_ptr = (m_id + 1) % N;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        hist.push_back(a[m_owner] == b[m_owner]);
        m_runs++;
        if (trailing_matches() >= RL) begin
          m_done = 1; m_hit = 1; m_report = 1; m_owner = -1;
        end else if (TMO_ON && m_runs >= TMO) begin
          m_done = 1; m_hit = 0; m_report = 1; m_owner = -1;
        end
      end
    end else if (req != 0) begin
      for (int k = 0; k < N; k++) begin
        int idx = (m_ptr + k) % N;
        if (m_owner < 0 && req[idx]) m_owner = idx;
      end
      m_id = m_owner;
      m_runs = 0;
      hist.delete();
    end
  endtask

  task automatic compare();
    logic [31:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check("gnt", 32'(gnt), exp_gnt);
    check("done", 32'(done), 32'(m_done));
    if (m_done) check("hit", 32'(hit), 32'(m_hit));
    if (exp_gnt != 0 || m_done) check("id", 32'(id), 32'(m_id));
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_id", 32'(id), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_gnt", 32'(gnt), 32'd0);
    reset = 1'b1;
  endtask

  task automatic drive_match();
    a = N'($urandom);
    b = a;
  endtask

  task automatic drive_mismatch();
    a = N'($urandom);
    b = ~a;
  endtask

  int last_done, cyc, dcount;

  initial begin
    model_reset();
    #1;
    do_reset();

    // single requester, always matching: grant next edge, done RL edges later
    req = 4'b0001; drive_match();
    step();
    check("t29_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < RL - 1; i++) begin
      drive_match(); step();
      check("t29_nodone", 32'(done), 32'd0);
    end
    drive_match(); step();
    check("t29_done", 32'(done), 32'd1);
    check("t29_hit", 32'(hit), 32'd1);
    check("t29_id", 32'(id), 32'd0);
    req = '0; step(); step();

    // a mismatch restarts the run: hit only on the 7th sample
    do_reset();
    req = 4'b0001; drive_match();
    step();
    for (int i = 0; i < 7; i++) begin
      if (i == 2) drive_mismatch(); else drive_match();
      step();
      check("t30_done", 32'(done), (i == 6) ? 32'd1 : 32'd0);
    end
    req = '0; step(); step();

    // all requesting: round-robin order 0,1,2,3,0, one done pulse apart
    do_reset();
    req = 4'b1111;
    exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    last_done = -1;
    for (cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
      drive_match(); step();
      if (done) begin
        check("t31_order", 32'(id), exp_q.pop_front());
        if (last_done >= 0) check("t31_gap", 32'(cyc - last_done), 32'(RL + 2));
        last_done = cyc;
      end
    end
    check("t31_left", 32'(exp_q.size()), 32'd0);
    req = '0; step(); step(); step();

    // abandon after 2 run cycles, next grant goes to index 3
    do_reset();
    req = 4'b0100; drive_mismatch();
    step();
    check("t32_gnt2", 32'(gnt), 32'h4);
    drive_mismatch(); step();
    drive_mismatch(); step();
    req = 4'b1001; drive_match();
    step();
    check("t32_abandon", 32'(gnt), 32'd0);
    check("t32_nodone", 32'(done), 32'd0);
    step();
    check("t32_gnt3", 32'(gnt), 32'h8);
    req = '0; step(); step();

    // never matching: timeout result or no result at all
    do_reset();
    req = 4'b0001; drive_mismatch();
    step();
    dcount = 0;
    for (int i = 0; i < (TMO_ON ? TMO : 100); i++) begin
      drive_mismatch(); step();
      if (done) dcount++;
    end
    if (TMO_ON) begin
      check("t33_tmo_done", 32'(done), 32'd1);
      check("t33_tmo_hit", 32'(hit), 32'd0);
    end else begin
      check("t33_no_done", 32'(dcount), 32'd0);
    end
    req = '0; step(); step();

    // reset mid-run discards the transaction
    do_reset();
    req = 4'b0001; drive_match();
    step();
    for (int i = 0; i < 3; i++) begin
      drive_match(); step();
    end
    do_reset();
    req = 4'b1000; drive_match();
    step();
    check("t34_gnt", 32'(gnt), 32'h8);
    check("t34_nodone", 32'(done), 32'd0);
    req = '0; step(); step();

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 9) == 0) req[k] = ~req[k];
        a[k] = 1'($urandom);
        b[k] = ($urandom_range(0, 5) == 0) ? ~a[k] : a[k];
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
